// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic [31:0] PWM_DEFAULT_PERIOD = '1;

  function automatic int sel_period(input int channels);
    return channels;
  endfunction

  function automatic int pwm_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Configuration write bus for pwm_multi_ch.
interface pwm_multi_ch_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 5
);
  logic             cfg_wr;
  logic [SEL_W-1:0] cfg_sel;
  logic [WIDTH-1:0] cfg_data;

  modport master (
    output cfg_wr,
    output cfg_sel,
    output cfg_data
  );

  modport slave (
    input cfg_wr,
    input cfg_sel,
    input cfg_data
  );
endinterface

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: active duty register, compare and output flop.
module pwm_cmp_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] duty_sh,
  input  logic [WIDTH-1:0] counter,
  output logic             pwm_o
);
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic             pwm_q;
  logic             pwm_d;

  always_comb begin
    duty_d = load ? duty_sh : duty_q;
    pwm_d  = pwm_q;
    if (clr) begin
      pwm_d = 1'b0;
    end else if (en) begin
      pwm_d = counter < duty_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared period counter, shadowed period/duty applied at wrap.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                sync_clr,
  pwm_multi_ch_if.slave       cfg,
  output logic                upd_pending,
  output logic                period_end,
  output logic [CHANNELS-1:0] pwm_o
);
  localparam logic [SEL_W-1:0] SEL_PER = SEL_W'(sel_period(CHANNELS));
  localparam logic [WIDTH-1:0] PER_RST = PWM_DEFAULT_PERIOD[WIDTH-1:0];

  if (SEL_W < pwm_clog2(CHANNELS + 1) || CHANNELS < 1 || CHANNELS > 16) begin : g_bad_cfg
    $error("pwm_multi_ch: invalid CHANNELS/SEL_W");
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] per_act_q;
  logic [WIDTH-1:0] per_act_d;
  logic [WIDTH-1:0] per_sh_q;
  logic [WIDTH-1:0] per_sh_d;
  logic [WIDTH-1:0] duty_sh_q [CHANNELS];
  logic [WIDTH-1:0] duty_sh_d [CHANNELS];
  logic             pend_q;
  logic             pend_d;
  logic             pe_q;
  logic             pe_d;

  logic wrap;
  logic load;
  logic wr_ok;

  assign wrap  = en && !sync_clr && (cnt_q == per_act_q);
  assign load  = sync_clr || (wrap && pend_q);
  assign wr_ok = cfg.cfg_wr && (cfg.cfg_sel <= SEL_PER);

  // Shadow writes follow the transfer, so a write in the wrap cycle waits a period.
  always_comb begin
    cnt_d     = cnt_q;
    per_act_d = load ? per_sh_q : per_act_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    pend_d    = load ? 1'b0 : pend_q;
    pe_d      = wrap;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    if (wr_ok) begin
      pend_d = 1'b1;
      if (cfg.cfg_sel == SEL_PER) begin
        per_sh_d = cfg.cfg_data;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg.cfg_sel == SEL_W'(i)) begin
          duty_sh_d[i] = cfg.cfg_data;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      per_act_q <= PER_RST;
      per_sh_q  <= PER_RST;
      duty_sh_q <= '{default: '0};
      pend_q    <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_act_q <= per_act_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pend_q    <= pend_d;
      pe_q      <= pe_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_cmp_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .en     (en),
      .clr    (sync_clr),
      .load   (load),
      .duty_sh(duty_sh_q[g]),
      .counter(cnt_q),
      .pwm_o  (pwm_o[g])
    );
  end

  assign upd_pending = pend_q;
  assign period_end  = pe_q;
endmodule
